seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter N, default 4, meaning pattern length in bits; legal range 2..8.
REQ-002 SHALL have parameter PATTERN, default 4'b1101 (N bits), meaning target sequence; bit N-1 is received first.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed and 0 = detector restarts empty after a match.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port x, input, 1 bit: serial data bit, sampled on posedge clk when enable=1.
REQ-007 SHALL have port enable, input, 1 bit: sample qualifier.
REQ-008 SHALL have port clear, input, 1 bit: synchronous clear.
REQ-009 SHALL have port y, output reg, 1 bit: registered match flag.
REQ-010 SHALL have port count, output reg, 8 bits: match counter.

Function
REQ-011 SHALL keep state k = length of the longest PATTERN prefix matching the tail of the sampled stream; k is in 0..N-1, encoded in ceil(log2 N) bits.
REQ-012 SHALL, on an enabled sample with k < N-1, move to k+1 if x == PATTERN[N-1-k]; otherwise move to the longest prefix that is a suffix of (matched prefix, x), i.e. KMP fallback, computed for any legal PATTERN.
REQ-013 SHALL, on an enabled sample completing the pattern, set y=1 at that edge (Moore, one-cycle pulse).
REQ-014 SHALL, on that same completing edge, set k to the longest proper border of PATTERN if OVERLAP=1, else to 0.
REQ-015 SHALL set y=0 at every edge where no match completes, including edges with enable=0.
REQ-016 SHALL hold k unchanged while enable=0.
REQ-017 SHALL, when clear=1 at a posedge, set k=0, y=0 and count=0; clear overrides enable and x.
REQ-018 SHALL make y a direct register output with no combinational path from x to y.
REQ-019 SHALL never reach an unreachable state encoding; if one occurs, the next edge returns k to 0 with y=0.

Reset
REQ-020 SHALL, while reset=0, force k=0, y=0 and count=0 immediately, regardless of clk.
REQ-021 SHALL discard any partial match when reset is asserted mid-sequence; the first enabled edge after release starts from k=0.

Configuration
REQ-022 SHALL compile the match counter when macro SEQ_DETECTOR_COUNT_EN is defined:
- count increments by 1 on each edge where y is set to 1
- count saturates at 255 with no wrap
- clear and reset zero count
REQ-023 SHALL, without SEQ_DETECTOR_COUNT_EN:
- keep the count port
- drive count constant 8'd0
- contain no counter registers

Verification
REQ-024 SHALL pass: N=4, PATTERN=1101, OVERLAP=1, stream 1,1,0,1,1,0,1 with enable=1 -> y pulses after bits 4 and 7 only.
REQ-025 SHALL pass: the same stream with OVERLAP=0 -> y pulses after bit 4 only.
REQ-026 SHALL pass: N=3, PATTERN=111, OVERLAP=1, stream 1,1,1,1,1 -> y pulses after bits 3, 4 and 5; count=3 with the macro defined.
REQ-027 SHALL pass: stream 1,1,0, then reset low for half a cycle, then 1 -> no y pulse, and count unchanged at 0.
REQ-028 SHALL pass: stream 1,1, then enable=0 for 3 cycles with x=0, then enable=1 with 0,1 -> single y pulse on the final edge; stream 1,1,0 then clear=1, then 1 -> no pulse.
REQ-029 SHALL pass: 300 back-to-back matches with the macro defined -> count=255 and holding; without the macro -> count=0 throughout.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial pattern detector. Tracks k, the length of the longest PATTERN prefix
// that matches the tail of the sampled stream, using a KMP-style fallback
// derived at elaboration time for any PATTERN. Bit N-1 of PATTERN is the first
// bit expected on the wire. A completed match raises y for exactly one cycle.
//
// Parameters
//   N        pattern length in bits (2..8)
//   PATTERN  target sequence, N bits, MSB received first
//   OVERLAP  1: after a match, resume from the longest proper border
//            0: after a match, restart with nothing matched
//
// Ports
//   clk     in   single clock, all state changes on posedge
//   reset   in   asynchronous, active-low reset
//   x       in   serial data bit, sampled when enable=1
//   enable  in   sample qualifier
//   clear   in   synchronous clear of state, y and count (wins over enable)
//   y       out  registered one-cycle match flag
//   count   out  8-bit saturating match counter
//
// Build option
//   SEQ_DETECTOR_COUNT_EN  when defined, count is a saturating counter of
//                          matches; otherwise count is tied to zero and no
//                          counter register exists.
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       enable,
    input  logic       clear,
    output logic       y,
    output logic [7:0] count
);

    localparam int KW = $clog2(N);

    // Longest proper border of PATTERN (prefix that is also a suffix).
    function automatic int border_len();
        int  len;
        logic ok;
        len = 0;
        for (int j = 1; j < N; j++) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i < j) begin
                    if (PATTERN[N-1-i] != PATTERN[j-1-i]) ok = 1'b0;
                end
            end
            if (ok) len = j;
        end
        return len;
    endfunction

    // Next prefix length after appending bit_in to the matched prefix of
    // length cur. Result N means the whole pattern just completed.
    function automatic logic [KW:0] advance(input logic [KW-1:0] cur,
                                            input logic          bit_in);
        logic [KW:0] best;
        logic        ok;
        logic        b;
        int          pos;
        best = '0;
        for (int j = 1; j <= N; j++) begin
            if (j <= int'(cur) + 1) begin
                ok = 1'b1;
                for (int t = 0; t < N; t++) begin
                    if (t < j) begin
                        // Bit t of the candidate suffix of (prefix, bit_in).
                        pos = int'(cur) + 1 - j + t;
                        b   = (pos == int'(cur)) ? bit_in : PATTERN[N-1-pos];
                        if (b != PATTERN[N-1-t]) ok = 1'b0;
                    end
                end
                if (ok) best = (KW+1)'(j);
            end
        end
        return best;
    endfunction

    localparam logic [KW-1:0] RESTART = OVERLAP ? KW'(border_len()) : '0;
    localparam logic [KW:0]   FULL    = (KW+1)'(N);

    logic [KW-1:0] k;
    logic [KW:0]   nxt;
    logic          legal;
    logic          match;

    always_comb begin
        nxt   = advance(k, x);
        // Encodings above N-1 only exist when N is not a power of two.
        legal = (int'(k) <= N - 1);
        match = legal && enable && !clear && (nxt == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= '0;
            y <= 1'b0;
        end else begin
            y <= match;
            if (clear || !legal) begin
                k <= '0;
            end else if (enable) begin
                k <= match ? RESTART : nxt[KW-1:0];
            end
        end
    end

`ifdef SEQ_DETECTOR_COUNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (match) begin
            count <= sat_inc(count);
        end
    end
`else
    assign count = 8'd0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Drives three detector instances from one shared stimulus stream:
//   u_ov : N=4, PATTERN=1101, OVERLAP=1
//   u_no : N=4, PATTERN=1101, OVERLAP=0
//   u_d3 : N=3, PATTERN=111,  OVERLAP=1
// A sliding-window reference model computes the expected y and count of each
// instance when a step is driven; results are queued and compared after the
// clock edge.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic clk;
    logic reset;
    logic x;
    logic enable;
    logic clear;

    logic       y_ov, y_no, y_d3;
    logic [7:0] cnt_ov, cnt_no, cnt_d3;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_ov (
        .clk(clk), .reset(reset), .x(x), .enable(enable), .clear(clear),
        .y(y_ov), .count(cnt_ov)
    );

    seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) u_no (
        .clk(clk), .reset(reset), .x(x), .enable(enable), .clear(clear),
        .y(y_no), .count(cnt_no)
    );

    seq_detector_param #(.N(3), .PATTERN(3'b111), .OVERLAP(1'b1)) u_d3 (
        .clk(clk), .reset(reset), .x(x), .enable(enable), .clear(clear),
        .y(y_d3), .count(cnt_d3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]      y;
        logic [2:0][7:0] c;
    } exp_t;

    exp_t sb[$];

    int         n_of  [3] = '{4, 4, 3};
    logic [7:0] pat_of[3] = '{8'h0D, 8'h0D, 8'h07};
    bit         ov_of [3] = '{1'b1, 1'b0, 1'b1};

    logic [7:0] hist[3];
    int         fill[3];
    logic [7:0] mcnt[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = 8'd0;
            fill[i] = 0;
            mcnt[i] = 8'd0;
        end
    endtask

    // Reference: a match completes when the last N enabled bits equal the
    // pattern and at least N bits arrived since the last restart point.
    task automatic model_push(input bit xb, input bit en, input bit clr);
        exp_t       e;
        logic [7:0] mask;
        logic       ey;
        for (int i = 0; i < 3; i++) begin
            ey = 1'b0;
            if (clr) begin
                hist[i] = 8'd0;
                fill[i] = 0;
                mcnt[i] = 8'd0;
            end else if (en) begin
                hist[i] = {hist[i][6:0], xb};
                if (fill[i] < 255) fill[i]++;
                mask = 8'((1 << n_of[i]) - 1);
                if (fill[i] >= n_of[i] && (hist[i] & mask) == pat_of[i]) begin
                    ey = 1'b1;
                    if (mcnt[i] != 8'hFF) mcnt[i]++;
                    if (!ov_of[i]) fill[i] = 0;
                end
            end
            e.y[i] = ey;
`ifdef SEQ_DETECTOR_COUNT_EN
            e.c[i] = mcnt[i];
`else
            e.c[i] = 8'd0;
`endif
        end
        sb.push_back(e);
    endtask

    task automatic compare_outputs(input string tag);
        exp_t            e;
        logic [2:0]      yv;
        logic [2:0][7:0] cv;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard: got size %0d expected nonzero", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            yv = {y_d3, y_no, y_ov};
            cv = {cnt_d3, cnt_no, cnt_ov};
            for (int i = 0; i < 3; i++) begin
                checks++;
                assert (yv[i] === e.y[i]) else begin
                    errors++;
                    $error("FAIL %s y[%0d]: got %b expected %b", tag, i, yv[i], e.y[i]);
                end
                checks++;
                assert (cv[i] === e.c[i]) else begin
                    errors++;
                    $error("FAIL %s count[%0d]: got %0d expected %0d", tag, i, cv[i], e.c[i]);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        logic [2:0]  yv;
        logic [23:0] cv;
        yv = {y_d3, y_no, y_ov};
        cv = {cnt_d3, cnt_no, cnt_ov};
        checks++;
        assert (yv === 3'b000) else begin
            errors++;
            $error("FAIL %s y: got %b expected 000", tag, yv);
        end
        checks++;
        assert (cv === 24'd0) else begin
            errors++;
            $error("FAIL %s count: got %h expected 000000", tag, cv);
        end
    endtask

    // Inputs change 1 time unit after a posedge; outputs are checked 1 time
    // unit after the following posedge.
    task automatic step(input bit xb, input bit en, input bit clr, input string tag);
        x      = xb;
        enable = en;
        clear  = clr;
        model_push(xb, en, clr);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        reset  = 1'b0;
        x      = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        model_reset();

        #3;
        check_zero("reset_before_edge");
        @(posedge clk);
        #1;
        check_zero("reset_after_edge");
        reset = 1'b1;

        // Partial match 1,1,0 then reset pulse of half a cycle, then 1.
        step(1'b1, 1'b1, 1'b0, "rst_mid_b1");
        step(1'b1, 1'b1, 1'b0, "rst_mid_b2");
        step(1'b0, 1'b1, 1'b0, "rst_mid_b3");
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("rst_mid_async");
        #4;
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, "rst_mid_after");

        // Stream 1,1,0,1,1,0,1.
        step(1'b0, 1'b0, 1'b1, "clr_a");
        step(1'b1, 1'b1, 1'b0, "s24_b1");
        step(1'b1, 1'b1, 1'b0, "s24_b2");
        step(1'b0, 1'b1, 1'b0, "s24_b3");
        step(1'b1, 1'b1, 1'b0, "s24_b4");
        step(1'b1, 1'b1, 1'b0, "s24_b5");
        step(1'b0, 1'b1, 1'b0, "s24_b6");
        step(1'b1, 1'b1, 1'b0, "s24_b7");
        step(1'b0, 1'b0, 1'b0, "s24_idle");

        // Stream of five ones.
        step(1'b0, 1'b0, 1'b1, "clr_b");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, "ones5");
        step(1'b1, 1'b0, 1'b0, "ones5_hold");

        // 1,1, enable low for 3 cycles with x=0, then 0,1.
        step(1'b0, 1'b0, 1'b1, "clr_c");
        step(1'b1, 1'b1, 1'b0, "en_b1");
        step(1'b1, 1'b1, 1'b0, "en_b2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "en_off");
        step(1'b0, 1'b1, 1'b0, "en_b3");
        step(1'b1, 1'b1, 1'b0, "en_b4");

        // 1,1,0 then clear (with x=1, enable=1), then 1.
        step(1'b1, 1'b1, 1'b0, "clr_seq_b1");
        step(1'b1, 1'b1, 1'b0, "clr_seq_b2");
        step(1'b0, 1'b1, 1'b0, "clr_seq_b3");
        step(1'b1, 1'b1, 1'b1, "clr_seq_clr");
        step(1'b1, 1'b1, 1'b0, "clr_seq_b4");

        // 302 ones: 300 back-to-back overlapping matches for the 111 detector.
        step(1'b0, 1'b0, 1'b1, "clr_d");
        for (int i = 0; i < 302; i++) step(1'b1, 1'b1, 1'b0, "sat_ones");
        step(1'b0, 1'b0, 1'b0, "sat_ones_hold");

        // 300 repetitions of 1101 for the N=4 detectors.
        step(1'b0, 1'b0, 1'b1, "clr_e");
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b0, "sat_rep");
            step(1'b1, 1'b1, 1'b0, "sat_rep");
            step(1'b0, 1'b1, 1'b0, "sat_rep");
            step(1'b1, 1'b1, 1'b0, "sat_rep");
        end
        step(1'b0, 1'b0, 1'b0, "sat_rep_hold");
        step(1'b1, 1'b1, 1'b0, "sat_rep_tail");

        // Clear zeroes a saturated counter.
        step(1'b0, 1'b0, 1'b1, "clr_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
